// File: rtl/cpu_pkg.sv
// cpu_pkg: register indices and address type shared by the Thumb pipeline.
package cpu_pkg;
    typedef logic [3:0] reg_addr_t;
    localparam reg_addr_t REG_SP = 4'd13;
    localparam reg_addr_t REG_LR = 4'd14;
    localparam reg_addr_t REG_PC = 4'd15;
    localparam int NUM_REGS = 16;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register saturating pending-write counters with hazard lookup and sticky error.
module wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int SB_W = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      stall,
    input  logic      issue_en,
    input  reg_addr_t issue_addr,
    input  logic      retire_en,
    input  reg_addr_t retire_addr,
    input  reg_addr_t rd_addr_a,
    input  reg_addr_t rd_addr_b,
    input  logic      byp_a,
    input  logic      byp_b,
    output logic      hazard_a,
    output logic      hazard_b,
    output logic      err_r
);
    localparam logic [SB_W-1:0] MAX = '1;
    logic [NUM_REGS-1:0][SB_W-1:0] cnt;
    logic [NUM_REGS-1:0] ovf, unf;
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        logic iss, ret;
        logic [SB_W-1:0] c;
        assign iss = !stall && issue_en && issue_addr == reg_addr_t'(r);
        assign ret = !stall && retire_en && retire_addr == reg_addr_t'(r);
        assign ovf[r] = iss && !ret && c == MAX;
        assign unf[r] = ret && !iss && c == '0;
        assign cnt[r] = c;
        always_ff @(posedge clk) begin
            if (rst)
                c <= '0;
            else if (iss != ret && !ovf[r] && !unf[r])
                c <= iss ? c + 1'b1 : c - 1'b1;
        end
    end
    // A bypassed read is satisfied by the retiring write, leaving one fewer pending.
    assign hazard_a = cnt[rd_addr_a] != SB_W'(byp_a);
    assign hazard_b = cnt[rd_addr_b] != SB_W'(byp_b);
    always_ff @(posedge clk) begin
        if (rst)
            err_r <= 1'b0;
        else if (|ovf || |unf)
            err_r <= 1'b1;
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback register file R0-R14, R15 redirect pulse, two read ports, RAW scoreboard.
// Define WB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_0FFC,
    parameter int              SB_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_wr_en,
    input  reg_addr_t         i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_issue_en,
    input  reg_addr_t         i_issue_addr,
    input  reg_addr_t         i_rd_addr_a,
    input  reg_addr_t         i_rd_addr_b,
    input  logic [DATA_W-1:0] i_pc,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic [DATA_W-1:0] o_rd_data_b,
    output logic              o_hazard_a,
    output logic              o_hazard_b,
    output logic              o_pc_wr_r,
    output logic [DATA_W-1:0] o_pc_data_r,
    output logic              o_sb_err_r
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] wdata;
    logic commit, byp_a, byp_b;
    assign commit = i_wr_en && !i_stall;
    assign wdata = (i_wr_addr == REG_SP) ? {i_wr_data[DATA_W-1:2], 2'b00} : i_wr_data;
`ifdef WB_BYPASS_EN
    assign byp_a = commit && i_wr_addr == i_rd_addr_a && i_rd_addr_a != REG_PC;
    assign byp_b = commit && i_wr_addr == i_rd_addr_b && i_rd_addr_b != REG_PC;
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
            o_pc_wr_r   <= 1'b0;
            o_pc_data_r <= '0;
        end else begin
            o_pc_wr_r <= commit && i_wr_addr == REG_PC;
            if (commit && i_wr_addr == REG_PC)
                o_pc_data_r <= i_wr_data;
            if (commit && i_wr_addr != REG_PC)
                regs[i_wr_addr] <= wdata;
        end
    end
    always_comb begin
        o_rd_data_a = (i_rd_addr_a == REG_PC) ? i_pc : byp_a ? wdata : regs[i_rd_addr_a];
        o_rd_data_b = (i_rd_addr_b == REG_PC) ? i_pc : byp_b ? wdata : regs[i_rd_addr_b];
    end
    wb_scoreboard #(.SB_W(SB_W)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .stall      (i_stall),
        .issue_en   (i_issue_en),
        .issue_addr (i_issue_addr),
        .retire_en  (i_wr_en),
        .retire_addr(i_wr_addr),
        .rd_addr_a  (i_rd_addr_a),
        .rd_addr_b  (i_rd_addr_b),
        .byp_a      (byp_a),
        .byp_b      (byp_b),
        .hazard_a   (o_hazard_a),
        .hazard_b   (o_hazard_b),
        .err_r      (o_sb_err_r)
    );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and random stimulus against an array-based register file model.
module tb_wb_regfile;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int CNT_MAX = 3;
    logic clk = 1'b0, rst = 1'b1;
    logic i_stall = 0, i_wr_en = 0, i_issue_en = 0;
    logic [3:0] i_wr_addr = 0, i_issue_addr = 0, i_rd_addr_a = 0, i_rd_addr_b = 0;
    logic [31:0] i_wr_data = 0, i_pc = 32'h100;
    logic [31:0] o_rd_data_a, o_rd_data_b, o_pc_data_r;
    logic o_hazard_a, o_hazard_b, o_pc_wr_r, o_sb_err_r;
    logic [31:0] m_reg [16];
    int m_cnt [16];
    bit m_err, m_pcw;
    logic [31:0] m_pcd;
    int n_vec = 0, n_bad = 0;

    wb_regfile dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_issue_en(i_issue_en), .i_issue_addr(i_issue_addr),
        .i_rd_addr_a(i_rd_addr_a), .i_rd_addr_b(i_rd_addr_b), .i_pc(i_pc),
        .o_rd_data_a(o_rd_data_a), .o_rd_data_b(o_rd_data_b), .o_hazard_a(o_hazard_a),
        .o_hazard_b(o_hazard_b), .o_pc_wr_r(o_pc_wr_r), .o_pc_data_r(o_pc_data_r),
        .o_sb_err_r(o_sb_err_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] wval(input logic [3:0] a, input logic [31:0] d);
        return (a == 4'd13) ? (d & ~32'h3) : d;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (a == 4'd15) return i_pc;
        if (BYP && i_wr_en && !i_stall && i_wr_addr == a) return wval(a, i_wr_data);
        return m_reg[a];
    endfunction

    function automatic logic exp_hz(input logic [3:0] a);
        if (BYP && i_wr_en && !i_stall && i_wr_addr == a && a != 4'd15) return m_cnt[a] != 1;
        return m_cnt[a] != 0;
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[i] = (i == 13) ? 32'h0FFC : 32'h0;
                m_cnt[i] = 0;
            end
            m_err = 0; m_pcw = 0; m_pcd = 0;
        end else if (i_stall) begin
            m_pcw = 0;
        end else begin
            m_pcw = i_wr_en && i_wr_addr == 4'd15;
            if (m_pcw) m_pcd = i_wr_data;
            else if (i_wr_en) m_reg[i_wr_addr] = wval(i_wr_addr, i_wr_data);
            if (!(i_issue_en && i_wr_en && i_issue_addr == i_wr_addr)) begin
                if (i_issue_en) begin
                    if (m_cnt[i_issue_addr] == CNT_MAX) m_err = 1;
                    else m_cnt[i_issue_addr]++;
                end
                if (i_wr_en) begin
                    if (m_cnt[i_wr_addr] == 0) m_err = 1;
                    else m_cnt[i_wr_addr]--;
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        if (!rst) begin
            check("rd_a", o_rd_data_a, exp_rd(i_rd_addr_a));
            check("rd_b", o_rd_data_b, exp_rd(i_rd_addr_b));
            check("hz_a", 32'(o_hazard_a), 32'(exp_hz(i_rd_addr_a)));
            check("hz_b", 32'(o_hazard_b), 32'(exp_hz(i_rd_addr_b)));
        end
        @(posedge clk);
        model_update();
        #1;
        check("pc_wr", 32'(o_pc_wr_r), 32'(m_pcw));
        check("pc_data", o_pc_data_r, m_pcd);
        check("sb_err", 32'(o_sb_err_r), 32'(m_err));
    endtask

    task automatic idle();
        i_wr_en = 0; i_issue_en = 0; i_stall = 0; rst = 0;
    endtask

    initial begin
        tick();
        idle();
        for (int a = 0; a < 16; a++) begin
            i_rd_addr_a = 4'(a); i_rd_addr_b = 4'(15 - a);
            tick();
            check("t1_reset_read", o_rd_data_a, a == 13 ? 32'h0FFC : a == 15 ? 32'h100 : 32'h0);
        end
        i_wr_en = 1; i_wr_addr = 3; i_wr_data = 32'hDEAD_BEEF; i_rd_addr_a = 3;
        #1 check("t2_same_cycle", o_rd_data_a, BYP ? 32'hDEAD_BEEF : 32'h0);
        tick();
        idle();
        tick();
        check("t2_next_cycle", o_rd_data_a, 32'hDEAD_BEEF);
        i_wr_en = 1; i_wr_addr = 13; i_wr_data = 32'h0000_1237;
        tick();
        idle(); i_rd_addr_a = 13;
        tick();
        check("t3_sp_align", o_rd_data_a, 32'h0000_1234);
        i_wr_en = 1; i_wr_addr = 15; i_wr_data = 32'h40; i_rd_addr_a = 15;
        tick();
        check("t3_pc_pulse", 32'(o_pc_wr_r), 32'h1);
        check("t3_pc_data", o_pc_data_r, 32'h40);
        idle();
        tick();
        check("t3_pc_pulse_end", 32'(o_pc_wr_r), 32'h0);
        check("t3_r15_read", o_rd_data_a, 32'h100);
        i_issue_en = 1; i_issue_addr = 5;
        tick(); tick();
        idle(); i_rd_addr_a = 5;
        tick();
        check("t4_hz_cnt2", 32'(o_hazard_a), 32'h1);
        i_wr_en = 1; i_wr_addr = 5;
        tick();
        idle();
        tick();
        check("t4_hz_cnt1", 32'(o_hazard_a), 32'h1);
        i_wr_en = 1; i_issue_en = 1; i_issue_addr = 5;
        tick();
        idle();
        tick();
        check("t4_issue_retire", 32'(o_hazard_a), 32'h1);
        i_wr_en = 1;
        tick();
        idle();
        tick();
        check("t4_hz_cnt0", 32'(o_hazard_a), 32'h0);
        i_stall = 1; i_wr_en = 1; i_wr_addr = 2; i_wr_data = 7; i_issue_en = 1; i_issue_addr = 2;
        i_rd_addr_a = 2;
        tick();
        check("t5_stall_pcwr", 32'(o_pc_wr_r), 32'h0);
        idle();
        tick();
        check("t5_stall_reg", o_rd_data_a, 32'h0);
        check("t5_stall_hz", 32'(o_hazard_a), 32'h0);
        i_issue_en = 1; i_issue_addr = 1;
        repeat (4) tick();
        idle();
        tick();
        check("t6_ovf_err", 32'(o_sb_err_r), 32'h1);
        i_wr_en = 1; i_wr_addr = 4; i_rd_addr_a = 4;
        tick();
        idle();
        tick();
        check("t6_unf_hz", 32'(o_hazard_a), 32'h0);
        check("t6_sticky", 32'(o_sb_err_r), 32'h1);
        rst = 1;
        tick();
        check("t6_rst_clear", 32'(o_sb_err_r), 32'h0);
        idle();
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            i_stall      = ($urandom_range(0, 7) == 0);
            i_wr_en      = ($urandom_range(0, 2) == 0);
            i_issue_en   = ($urandom_range(0, 2) == 0);
            i_wr_addr    = 4'($urandom_range(0, 3) == 0 ? $urandom_range(8, 15) : $urandom_range(0, 7));
            i_issue_addr = 4'($urandom_range(0, 7));
            i_rd_addr_a  = $urandom_range(0, 1) ? i_wr_addr : 4'($urandom_range(0, 15));
            i_rd_addr_b  = 4'($urandom_range(0, 15));
            i_wr_data    = $urandom;
            i_pc         = $urandom;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
